// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the bubble-sort engine: default geometry and the
// controller state encoding.
// -----------------------------------------------------------------------------
package sort_pkg;

    // Default index width (entry count is 2**N) and data width.
    localparam int DEF_N = 2;
    localparam int DEF_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUTER = 2'd1,
        INNER = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : sort_pkg

// File: rtl/bubble_sort_engine_cmp_swap.sv
// -----------------------------------------------------------------------------
// cmp_swap
// Combinational compare-exchange of one adjacent pair.
//   a, b     : current values at the lower and higher index
//   descend  : 0 = ascending order, 1 = descending order
//   lo_out   : value to store at the lower index
//   hi_out   : value to store at the higher index
//   swapped  : pair was strictly out of order and has been exchanged
// Equal values are never exchanged, which keeps the sort stable.
// -----------------------------------------------------------------------------
module cmp_swap #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         descend,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out,
    output logic         swapped
);

    // Strict unsigned compare selects whether the pair is exchanged.
    always_comb begin
        swapped = 1'b0;
        lo_out  = a;
        hi_out  = b;
        if (descend) begin
            swapped = (a < b);
        end else begin
            swapped = (a > b);
        end
        if (swapped) begin
            lo_out = b;
            hi_out = a;
        end else begin
            lo_out = a;
            hi_out = b;
        end
    end

endmodule : cmp_swap

// File: rtl/bubble_sort_engine.sv
// -----------------------------------------------------------------------------
// bubble_sort_engine
// In-place bubble sort over a 2**N x W flip-flop register file.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (clears array and controller)
//   wr_en    : write strobe, honoured only while idle
//   wr_addr  : write index
//   wr_data  : write value
//   start    : begin sort, honoured only while idle
//   rd_addr  : read index
//   rd_data  : combinational read of entry rd_addr (valid in every state)
//   busy     : high while a sort is in progress (registered)
//   done     : one-cycle pulse after a sort completes (registered)
// Latency is data independent: busy lasts M(M+1)/2 cycles, M = 2**N.
// -----------------------------------------------------------------------------
module bubble_sort_engine
    import sort_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int DESCEND = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [N-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    input  logic [N-1:0] rd_addr,
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         done
);

    localparam int M = 1 << N;
    // Last outer pass index and the inner-loop limit of the first pass.
    localparam logic [N-1:0] LAST_I  = N'(M - 1);
    localparam logic [N-1:0] LAST_J0 = N'(M - 2);

    state_t         state_r;
    state_t         state_next_s;
    logic [N-1:0]   i_r;
    logic [N-1:0]   i_next_s;
    logic [N-1:0]   j_r;
    logic [N-1:0]   j_next_s;
    logic [N-1:0]   j_p1_s;
    logic [N-1:0]   j_last_s;
    logic [W-1:0]   mem_r [M];
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   lo_s;
    logic [W-1:0]   hi_s;
    logic           swapped_s;

    assign j_p1_s   = j_r + N'(1);
    // Each pass bubbles one more extreme value to the top, so it ends earlier.
    assign j_last_s = LAST_J0 - i_r;

    cmp_swap #(
        .W (W)
    ) u_cmp_swap (
        .a       (mem_r[j_r]),
        .b       (mem_r[j_p1_s]),
        .descend (DESCEND != 0),
        .lo_out  (lo_s),
        .hi_out  (hi_s),
        .swapped (swapped_s)
    );

    // Next-state and loop-index computation.
    always_comb begin
        state_next_s = state_r;
        i_next_s     = i_r;
        j_next_s     = j_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = OUTER;
                    i_next_s     = {N{1'b0}};
                    j_next_s     = {N{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            OUTER: begin
                j_next_s = {N{1'b0}};
                if (i_r == LAST_I) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = INNER;
                end
            end
            INNER: begin
                if (j_r == j_last_s) begin
                    i_next_s     = i_r + N'(1);
                    state_next_s = OUTER;
                end else begin
                    j_next_s     = j_p1_s;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Controller registers; busy/done are decoded from the next state so they
    // come straight from flops and line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            i_r     <= {N{1'b0}};
            j_r     <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            i_r     <= i_next_s;
            j_r     <= j_next_s;
            busy_r  <= (state_next_s == OUTER) || (state_next_s == INNER);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Register file: loader writes while idle, pair update during INNER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                mem_r[k] <= {W{1'b0}};
            end
        end else if (state_r == IDLE) begin
            if (wr_en) begin
                mem_r[wr_addr] <= wr_data;
            end
        end else if ((state_r == INNER) && swapped_s) begin
            mem_r[j_r]    <= lo_s;
            mem_r[j_p1_s] <= hi_s;
        end
    end

    assign rd_data = mem_r[rd_addr];
    assign busy    = busy_r;
    assign done    = done_r;

endmodule : bubble_sort_engine

// File: tb/tb_bubble_sort_engine.sv
// -----------------------------------------------------------------------------
// tb_bubble_sort_engine
// Three engines share clk/rst: unit 0 (N=2 ascending), unit 1 (N=2
// descending), unit 2 (N=1 ascending). Results are compared against a plain
// selection-sort reference and the closed-form latency M(M+1)/2.
// -----------------------------------------------------------------------------
module tb_bubble_sort_engine;

    typedef int vec_t [4];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en   [3];
    logic [1:0] wr_addr [3];
    logic [7:0] wr_data [3];
    logic       start   [3];
    logic [1:0] rd_addr [3];
    logic [7:0] rd_data [3];
    logic       busy    [3];
    logic       done    [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bubble_sort_engine #(.N(2), .W(8), .DESCEND(0)) u_asc (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .start(start[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]));

    bubble_sort_engine #(.N(2), .W(8), .DESCEND(1)) u_desc (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .start(start[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]));

    bubble_sort_engine #(.N(1), .W(8), .DESCEND(0)) u_small (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_addr(wr_addr[2][0]),
        .wr_data(wr_data[2]), .start(start[2]), .rd_addr(rd_addr[2][0]),
        .rd_data(rd_data[2]), .busy(busy[2]), .done(done[2]));

    function automatic int m_of(input int u);
        return (u == 2) ? 2 : 4;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: selection sort of the first m entries.
    function automatic void ref_sort(input vec_t v, input int m, input bit desc,
                                     output vec_t o);
        int t;
        o = v;
        for (int a = 0; a < m; a++) begin
            for (int b = a + 1; b < m; b++) begin
                if (desc ? (o[b] > o[a]) : (o[b] < o[a])) begin
                    t = o[a]; o[a] = o[b]; o[b] = t;
                end
            end
        end
    endfunction

    task automatic readback(input int u, input vec_t exp, input string tag);
        for (int a = 0; a < m_of(u); a++) begin
            rd_addr[u] = 2'(a);
            #1;
            check_val($sformatf("%s_u%0d_a%0d", tag, u, a), int'(rd_data[u]), exp[a]);
        end
    endtask

    task automatic load(input int u, input vec_t v);
        for (int a = 0; a < m_of(u); a++) begin
            @(negedge clk);
            wr_en[u]   = 1'b1;
            wr_addr[u] = 2'(a);
            wr_data[u] = 8'(v[a]);
        end
        @(negedge clk);
        wr_en[u] = 1'b0;
        readback(u, v, "load");
    endtask

    // Start a sort (optionally with a same-cycle write), optionally inject a
    // write+start at busy cycle index inj, then check latency and done pulse.
    task automatic run_sort(input int u, input int inj, input bit ws_en,
                            input int ws_addr, input int ws_data, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int overlap  = 0;
        int lat;
        lat = m_of(u) * (m_of(u) + 1) / 2;
        @(negedge clk);
        start[u] = 1'b1;
        if (ws_en) begin
            wr_en[u]   = 1'b1;
            wr_addr[u] = 2'(ws_addr);
            wr_data[u] = 8'(ws_data);
        end
        @(negedge clk);
        start[u] = 1'b0;
        wr_en[u] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy[u]) busy_cnt++;
            if (done[u]) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                if (busy[u]) overlap++;
            end
            if (c == inj) begin
                wr_en[u]   = 1'b1;
                wr_addr[u] = 2'd0;
                wr_data[u] = 8'hFF;
                start[u]   = 1'b1;
            end else if (c == inj + 1) begin
                wr_en[u] = 1'b0;
                start[u] = 1'b0;
            end
            @(negedge clk);
        end
        check_val({tag, "_busy_cycles"}, busy_cnt, lat);
        check_val({tag, "_done_count"}, done_cnt, 1);
        check_val({tag, "_done_at"}, done_at, lat);
        check_val({tag, "_done_busy_overlap"}, overlap, 0);
    endtask

    task automatic sort_case(input int u, input vec_t v, input int inj, input string tag);
        vec_t exp;
        load(u, v);
        run_sort(u, inj, 1'b0, 0, 0, tag);
        ref_sort(v, m_of(u), (u == 1), exp);
        readback(u, exp, tag);
    endtask

    initial begin
        vec_t v;
        vec_t exp;
        vec_t zeros = '{0, 0, 0, 0};
        int   seen_busy;
        int   seen_done;

        for (int u = 0; u < 3; u++) begin
            wr_en[u] = 1'b0; wr_addr[u] = 2'd0; wr_data[u] = 8'd0;
            start[u] = 1'b0; rd_addr[u] = 2'd0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check_val($sformatf("reset_busy_u%0d", u), int'(busy[u]), 0);
            check_val($sformatf("reset_done_u%0d", u), int'(done[u]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) readback(u, zeros, "reset_data");

        // Directed cases.
        sort_case(0, '{3, 1, 2, 0}, -1, "asc_3120");
        sort_case(1, '{3, 1, 2, 0}, -1, "desc_3120");
        sort_case(0, '{5, 5, 1, 5}, -1, "asc_dups");
        sort_case(0, '{0, 1, 2, 3}, -1, "asc_sorted");
        sort_case(2, '{9, 4, 0, 0}, -1, "n1_94");

        // Write and second start while busy must be ignored.
        sort_case(0, '{3, 1, 2, 0}, 2, "busy_intrude");

        // Write and start in the same idle cycle on the N=1 unit: array
        // becomes [9,2] and must sort to [2,9].
        load(2, '{9, 4, 0, 0});
        run_sort(2, -1, 1'b1, 1, 2, "n1_wr_start");
        readback(2, '{2, 9, 0, 0}, "n1_wr_start");

        // Randomized cases; narrow value range on some to force duplicates.
        for (int r = 0; r < 6; r++) begin
            for (int u = 0; u < 3; u++) begin
                for (int a = 0; a < 4; a++) begin
                    v[a] = (r < 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
                end
                if (u == 2) begin
                    v[2] = 0; v[3] = 0;
                end
                sort_case(u, v, -1, $sformatf("rand%0d_u%0d", r, u));
            end
        end

        // Reset during the 5th busy cycle aborts the sort.
        load(0, '{3, 1, 2, 0});
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort_busy_before", int'(busy[0]), 1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", int'(busy[0]), 0);
        check_val("abort_done", int'(done[0]), 0);
        readback(0, zeros, "abort_data");
        @(negedge clk);
        rst = 1'b0;
        seen_busy = 0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_busy += int'(busy[0]);
            seen_done += int'(done[0]);
        end
        check_val("abort_no_busy", seen_busy, 0);
        check_val("abort_no_done", seen_done, 0);
        readback(0, zeros, "abort_data_after");

        // Engine is usable again after the abort.
        sort_case(0, '{2, 3, 0, 1}, -1, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bubble_sort_engine
